pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. Sits beside the decode stage and watches decoder outputs (register indices, syscall_op, break_op) and EX/MEM status. Generates stall/flush/redirect controls for hazards, taken branches and trap entry, and keeps a stall-cycle performance counter. All stage registers obey its stall_*/flush_* outputs.

---
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/branch/trap sequencing for the 5-stage core; controls are combinational from state and inputs.
// mem_busy freezes the whole pipe and all sequencing state; trap entry drains older work before redirecting.
module pipeline_ctrl #(
    parameter int TRAP_DRAIN_CYCLES = 2,
    parameter int XLEN              = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_syscall,
    input  logic            id_break,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] trap_vector,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            trap_valid,
    output logic [1:0]      trap_cause,
    output logic [31:0]     stall_count
);
    typedef enum logic [1:0] {
        RUN           = 2'd0,
        TRAP_DRAIN    = 2'd1,
        TRAP_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  drain_q, drain_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] count_q, count_d;

    logic branch, trap_req, rs1_hit, rs2_hit, load_use;

    assign branch   = ex_valid & ex_branch_taken;
    assign trap_req = id_valid & (id_syscall | id_break);
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= 3'd0;
            cause_q <= 2'b00;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cause_d = cause_q;
        if (!mem_busy) begin
            // An older taken branch cancels any trap sequence still in flight.
            if (branch) begin
                state_d = RUN;
                drain_d = 3'd0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (trap_req) begin
                            cause_d = id_break ? 2'b10 : 2'b01;
                            drain_d = 3'(TRAP_DRAIN_CYCLES);
                            state_d = TRAP_DRAIN;
                        end
                    end
                    TRAP_DRAIN: begin
                        drain_d = drain_q - 3'd1;
                        if (drain_q == 3'd1) begin
                            state_d = TRAP_REDIRECT;
                        end
                    end
                    TRAP_REDIRECT: state_d = RUN;
                    default:       state_d = RUN;
                endcase
            end
        end
        count_d = count_q + {31'd0, stall_id};
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        trap_valid  = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (branch) begin
                pc_redirect = 1'b1;
                pc_target   = ex_branch_target;
                flush_id    = 1'b1;
                flush_ex    = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (trap_req || load_use) begin
                            stall_if = 1'b1;
                            stall_id = 1'b1;
                            flush_ex = 1'b1;
                        end
                    end
                    TRAP_DRAIN: begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                    TRAP_REDIRECT: begin
                        pc_redirect = 1'b1;
                        pc_target   = trap_vector;
                        flush_id    = 1'b1;
                        flush_ex    = 1'b1;
                        trap_valid  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign trap_cause  = rst ? 2'b00 : cause_q;
    assign stall_count = rst ? 32'd0 : count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then biased random traffic, scored against a cycle model.
module tb_pipeline_ctrl;
    localparam int P    = 2;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_use_rs1, id_use_rs2, id_syscall, id_break;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            ex_valid, ex_mem_read, ex_branch_taken, mem_busy;
    logic [XLEN-1:0] ex_branch_target, trap_vector;
    logic            stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect, trap_valid;
    logic [XLEN-1:0] pc_target;
    logic [1:0]      trap_cause;
    logic [31:0]     stall_count;

    pipeline_ctrl #(.TRAP_DRAIN_CYCLES(P), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_syscall(id_syscall), .id_break(id_break),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mem_busy(mem_busy), .trap_vector(trap_vector),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s_if, s_id, s_ex, f_id, f_ex, redir, tvld;
        logic [31:0] target;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference: trap progress as "drain cycles left" plus a pending-redirect flag.
    int          m_left  = 0;
    bit          m_redir = 0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_cnt   = 32'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL cyc=%0d %s got=%h exp=%h", cyc, name, got, exp);
        end
    endtask

    task automatic model_push();
        exp_t e;
        bit   hazard;
        e = '{default: '0};
        hazard = ex_valid && ex_mem_read && ex_rd != 0 && id_valid &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst) begin
            m_left = 0; m_redir = 0; m_cause = 2'b00; m_cnt = 32'd0;
        end else begin
            e.cause = m_cause;
            e.cnt   = m_cnt;
            if (mem_busy) begin
                e.s_if = 1; e.s_id = 1; e.s_ex = 1;
            end else if (ex_valid && ex_branch_taken) begin
                e.redir = 1; e.target = ex_branch_target; e.f_id = 1; e.f_ex = 1;
                m_left = 0; m_redir = 0;
            end else if (m_redir) begin
                e.redir = 1; e.target = trap_vector; e.f_id = 1; e.f_ex = 1; e.tvld = 1;
                m_redir = 0;
            end else if (m_left > 0) begin
                e.s_if = 1; e.s_id = 1; e.f_ex = 1;
                m_left--;
                if (m_left == 0) m_redir = 1;
            end else if (id_valid && (id_syscall || id_break)) begin
                e.s_if = 1; e.s_id = 1; e.f_ex = 1;
                m_cause = id_break ? 2'b10 : 2'b01;
                m_left  = P;
            end else if (hazard) begin
                e.s_if = 1; e.s_id = 1; e.f_ex = 1;
            end
            if (e.s_id) m_cnt++;
        end
        sb.push_back(e);
    endtask

    task automatic step();
        model_push();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_syscall = 0; id_break = 0; ex_valid = 0; ex_rd = 0; ex_mem_read = 0;
        ex_branch_taken = 0; ex_branch_target = 0; mem_busy = 0; trap_vector = 32'h80;
    endtask

    task automatic load_use_setup();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_if", 32'(stall_if), 32'(e.s_if));
            chk("stall_id", 32'(stall_id), 32'(e.s_id));
            chk("stall_ex", 32'(stall_ex), 32'(e.s_ex));
            chk("flush_id", 32'(flush_id), 32'(e.f_id));
            chk("flush_ex", 32'(flush_ex), 32'(e.f_ex));
            chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
            chk("pc_target", pc_target, e.target);
            chk("trap_valid", 32'(trap_valid), 32'(e.tvld));
            chk("trap_cause", 32'(trap_cause), 32'(e.cause));
            chk("stall_count", stall_count, e.cnt);
        end
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        step(); step();
        idle();
        // load-use then bubble clears it
        load_use_setup(); step();
        ex_valid = 0; step();
        // rd zero never stalls
        idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 0; id_valid = 1; id_use_rs1 = 1; step();
        // branch beats concurrent load-use
        idle(); load_use_setup(); ex_branch_taken = 1; ex_branch_target = 32'h100; step();
        // syscall trap, full sequence
        idle(); id_valid = 1; id_syscall = 1; step();
        idle(); repeat (5) step();
        // syscall with mem_busy for 3 cycles mid-drain
        id_valid = 1; id_syscall = 1; step();
        idle(); step();
        mem_busy = 1; repeat (3) step();
        mem_busy = 0; repeat (4) step();
        // break and syscall together
        id_valid = 1; id_syscall = 1; id_break = 1; step();
        idle(); repeat (4) step();
        // branch during drain cancels the trap
        id_valid = 1; id_break = 1; step();
        idle(); ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h2000; step();
        idle(); repeat (3) step();
        // reset during drain abandons the trap
        id_valid = 1; id_syscall = 1; step();
        idle(); rst = 1; step();
        rst = 0; repeat (4) step();

        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            id_valid         = ($urandom_range(0, 3) != 0);
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom_range(0, 1));
            id_use_rs2       = 1'($urandom_range(0, 1));
            id_syscall       = ($urandom_range(0, 15) == 0);
            id_break         = ($urandom_range(0, 15) == 0);
            ex_valid         = ($urandom_range(0, 3) != 0);
            ex_rd            = 5'($urandom_range(0, 3));
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_branch_taken  = ($urandom_range(0, 9) == 0);
            ex_branch_target = $urandom;
            mem_busy         = ($urandom_range(0, 7) == 0);
            trap_vector      = $urandom;
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
